// File: rtl/cache_tag_pkg.sv
// Shared encodings for the cache tag controller: MSI states, request opcodes, FSM states.
// Also holds the tag-width derivation and the reserved-state folding helper.
package cache_tag_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] MSI_I    = 2'b00;
  localparam logic [STATE_W-1:0] MSI_S    = 2'b01;
  localparam logic [STATE_W-1:0] MSI_M    = 2'b10;
  localparam logic [STATE_W-1:0] MSI_RSVD = 2'b11;

  localparam logic OP_LOOKUP = 1'b0;
  localparam logic OP_UPDATE = 1'b1;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_LOOK = 2'd2,
    ST_RESP = 2'd3
  } ctrl_state_t;

  // Tag RAM entry is {state, tag}; the tag takes whatever is left after the state bits.
  function automatic int tag_width(input int dwidth);
    return dwidth - STATE_W;
  endfunction

  // The reserved encoding never survives into the RAM or a response: it reads as Invalid.
  function automatic logic [STATE_W-1:0] msi_sanitize(input logic [STATE_W-1:0] st);
    return (st == MSI_RSVD) ? MSI_I : st;
  endfunction

endpackage

// File: rtl/tag_hit_check.sv
// Combinational MSI/tag compare: zero latency, no flow control.
// A stored reserved state is reported as Invalid and can never hit.
module tag_hit_check
  import cache_tag_pkg::*;
#(
  parameter int TWIDTH = 9
) (
  input  logic [STATE_W-1:0] stored_state,
  input  logic [TWIDTH-1:0]  stored_tag,
  input  logic [TWIDTH-1:0]  cmp_tag,
  output logic               hit,
  output logic [STATE_W-1:0] eff_state
);

  always_comb begin
    eff_state = msi_sanitize(stored_state);
    hit       = (eff_state != MSI_I) && (stored_tag == cmp_tag);
  end

endmodule

// File: rtl/cache_tag_ctrl.sv
// Tag RAM controller: response 2 cycles after accept, one request per 3 cycles, req_ready only in IDLE.
// CACHE_TAG_INIT_SWEEP_EN: after reset, write Invalid to every entry before accepting requests.
module cache_tag_ctrl
  import cache_tag_pkg::*;
#(
  parameter  int AWIDTH = 3,
  parameter  int DWIDTH = 11,
  localparam int TWIDTH = tag_width(DWIDTH),
  localparam int DEPTH  = 1 << AWIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_op,
  input  logic [AWIDTH-1:0]  req_index,
  input  logic [TWIDTH-1:0]  req_tag,
  input  logic [STATE_W-1:0] req_state,
  output logic               rsp_valid,
  output logic               rsp_hit,
  output logic [STATE_W-1:0] rsp_state,
  output logic [TWIDTH-1:0]  rsp_tag,
  output logic [AWIDTH-1:0]  ram_addr,
  output logic [DWIDTH-1:0]  ram_din,
  output logic               ram_we,
  input  logic [DWIDTH-1:0]  ram_dout
);

  typedef struct packed {
    logic              op;
    logic [TWIDTH-1:0] tag;
  } req_cap_t;

  typedef struct packed {
    logic               hit;
    logic [STATE_W-1:0] state;
    logic [TWIDTH-1:0]  tag;
  } rsp_t;

`ifdef CACHE_TAG_INIT_SWEEP_EN
  localparam ctrl_state_t RESET_STATE = ST_INIT;
  logic [AWIDTH-1:0] sweep_q, sweep_d;
`else
  localparam ctrl_state_t RESET_STATE = ST_IDLE;
`endif

  ctrl_state_t state_q, state_d;
  req_cap_t    cap_q, cap_d;
  rsp_t        rsp_q, rsp_d;

  logic [STATE_W-1:0] stored_state;
  logic [TWIDTH-1:0]  stored_tag;
  logic               chk_hit;
  logic [STATE_W-1:0] chk_state;
  logic [STATE_W-1:0] wr_state;

  assign stored_state = ram_dout[DWIDTH-1 -: STATE_W];
  assign stored_tag   = ram_dout[TWIDTH-1:0];
  assign wr_state     = msi_sanitize(req_state);

  tag_hit_check #(
    .TWIDTH (TWIDTH)
  ) u_hit (
    .stored_state (stored_state),
    .stored_tag   (stored_tag),
    .cmp_tag      (cap_q.tag),
    .hit          (chk_hit),
    .eff_state    (chk_state)
  );

  always_comb begin
    state_d   = state_q;
    cap_d     = cap_q;
    rsp_d     = rsp_q;
    req_ready = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    ram_we    = 1'b0;
`ifdef CACHE_TAG_INIT_SWEEP_EN
    sweep_d   = sweep_q;
`endif

    case (state_q)
      ST_INIT: begin
`ifdef CACHE_TAG_INIT_SWEEP_EN
        ram_we   = 1'b1;
        ram_addr = sweep_q;
        sweep_d  = sweep_q + AWIDTH'(1);
        if (sweep_q == AWIDTH'(DEPTH - 1)) begin
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end

      ST_IDLE: begin
        req_ready = 1'b1;
        ram_addr  = req_index;
        if (req_valid) begin
          cap_d   = '{op: req_op, tag: req_tag};
          state_d = ST_LOOK;
          // An update writes through in the accept cycle; its response is known now.
          if (req_op == OP_UPDATE) begin
            ram_we  = 1'b1;
            ram_din = {wr_state, req_tag};
            rsp_d   = '{hit: 1'b1, state: wr_state, tag: req_tag};
          end
        end
      end

      ST_LOOK: begin
        if (cap_q.op == OP_LOOKUP) begin
          rsp_d = '{hit: chk_hit, state: chk_state, tag: stored_tag};
        end
        state_d = ST_RESP;
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Synchronous reset still forces every RAM-facing and handshake output quiet in-cycle.
    if (reset) begin
      req_ready = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_din   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RESET_STATE;
      cap_q   <= '0;
      rsp_q   <= '0;
`ifdef CACHE_TAG_INIT_SWEEP_EN
      sweep_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      rsp_q   <= rsp_d;
`ifdef CACHE_TAG_INIT_SWEEP_EN
      sweep_q <= sweep_d;
`endif
    end
  end

  assign rsp_valid = (state_q == ST_RESP) && !reset;
  assign rsp_hit   = rsp_valid & rsp_q.hit;
  assign rsp_state = rsp_valid ? rsp_q.state : '0;
  assign rsp_tag   = rsp_valid ? rsp_q.tag : '0;

  a_rsp_not_ready : assert property (@(posedge clock) disable iff (reset)
    rsp_valid |-> !req_ready);

  a_we_only_idle_init : assert property (@(posedge clock) disable iff (reset)
    ram_we |-> (state_q == ST_IDLE || state_q == ST_INIT));

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Bench for cache_tag_ctrl: directed scenarios with literal expectations plus a random phase
// checked each cycle against a transaction-level model of the tag store.
module tb_cache_tag_ctrl;

  localparam int AW    = 3;
  localparam int DW    = 11;
  localparam int TW    = 9;
  localparam int DEPTH = 8;
`ifdef CACHE_TAG_INIT_SWEEP_EN
  localparam bit SWEEP_ON = 1'b1;
`else
  localparam bit SWEEP_ON = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_op;
  logic [AW-1:0] req_index;
  logic [TW-1:0] req_tag;
  logic [1:0]    req_state;
  logic          rsp_valid, rsp_hit;
  logic [1:0]    rsp_state;
  logic [TW-1:0] rsp_tag;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  cache_tag_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_index (req_index),
    .req_tag   (req_tag),
    .req_state (req_state),
    .rsp_valid (rsp_valid),
    .rsp_hit   (rsp_hit),
    .rsp_state (rsp_state),
    .rsp_tag   (rsp_tag),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_dout  (ram_dout)
  );

  // External synchronous tag RAM with a random preload (stands in for the preload file).
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] pre [DEPTH];
  logic          loaded = 1'b0;

  always @(posedge clock) begin
    if (!loaded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= pre[i];
      loaded <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
    end
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: what the tag store holds, and how many cycles remain
  // before the controller is free again.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_sweep = 0;
  int            m_busy  = 0;
  logic          p_hit;
  logic [1:0]    p_st;
  logic [TW-1:0] p_tag;

  initial begin : compare_proc
    logic [1:0]    fixed;
    logic [DW-1:0] e;
    forever begin
      @(negedge clock);
      if (reset) begin
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_hit",   int'(rsp_hit), 0);
        chk("rst_rsp_state", int'(rsp_state), 0);
        chk("rst_rsp_tag",   int'(rsp_tag), 0);
        chk("rst_ram_we",    int'(ram_we), 0);
        chk("rst_ram_addr",  int'(ram_addr), 0);
        chk("rst_ram_din",   int'(ram_din), 0);
        m_sweep = SWEEP_ON ? DEPTH : 0;
        m_busy  = 0;
      end else if (m_sweep > 0) begin
        chk("sweep_ready", int'(req_ready), 0);
        chk("sweep_we",    int'(ram_we), 1);
        chk("sweep_addr",  int'(ram_addr), DEPTH - m_sweep);
        chk("sweep_din",   int'(ram_din), 0);
        chk("sweep_rsp",   int'(rsp_valid), 0);
        m_mem[DEPTH - m_sweep] = '0;
        m_sweep--;
      end else if (m_busy == 2) begin
        chk("look_ready", int'(req_ready), 0);
        chk("look_we",    int'(ram_we), 0);
        chk("look_rsp",   int'(rsp_valid), 0);
        m_busy = 1;
      end else if (m_busy == 1) begin
        chk("resp_ready", int'(req_ready), 0);
        chk("resp_we",    int'(ram_we), 0);
        chk("resp_valid", int'(rsp_valid), 1);
        chk("resp_hit",   int'(rsp_hit), int'(p_hit));
        chk("resp_state", int'(rsp_state), int'(p_st));
        chk("resp_tag",   int'(rsp_tag), int'(p_tag));
        m_busy = 0;
      end else begin
        chk("idle_ready", int'(req_ready), 1);
        chk("idle_rsp",   int'(rsp_valid), 0);
        chk("idle_addr",  int'(ram_addr), int'(req_index));
        chk("idle_we",    int'(ram_we), int'(req_valid && req_op));
        if (req_valid) begin
          if (req_op) begin
            fixed = (req_state == 2'b11) ? 2'b00 : req_state;
            chk("idle_din", int'(ram_din), int'({fixed, req_tag}));
            m_mem[req_index] = {fixed, req_tag};
            p_hit = 1'b1;
            p_st  = fixed;
            p_tag = req_tag;
          end else begin
            e     = m_mem[req_index];
            p_st  = (e[DW-1:TW] == 2'b11) ? 2'b00 : e[DW-1:TW];
            p_tag = e[TW-1:0];
            p_hit = (p_st != 2'b00) && (p_tag == req_tag);
          end
          m_busy = 2;
        end
      end
    end
  end

  // Issue one request, scramble the inputs after accept, and return the response
  // plus the number of cycles from the accept edge to rsp_valid.
  task automatic do_req(input logic op, input logic [AW-1:0] idx, input logic [TW-1:0] tg,
                        input logic [1:0] st, output logic h, output logic [1:0] s,
                        output logic [TW-1:0] t, output int lat);
    int n;
    @(posedge clock); #1;
    req_valid = 1'b1; req_op = op; req_index = idx; req_tag = tg; req_state = st;
    n = 0;
    @(negedge clock);
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) chk("accept_timeout", int'(req_ready), 1);
    @(posedge clock); #1;
    req_valid = 1'b0; req_op = ~op; req_index = ~idx; req_tag = ~tg; req_state = ~st;
    lat = 0; h = 1'b0; s = '0; t = '0;
    while (lat < 6) begin
      @(negedge clock);
      lat++;
      if (rsp_valid) break;
    end
    h = rsp_hit; s = rsp_state; t = rsp_tag;
  endtask

  initial begin : stim
    logic          h;
    logic [1:0]    s;
    logic [TW-1:0] t;
    int            lat, n, wes, acc;
    int            acc_at[$];

    for (int i = 0; i < DEPTH; i++) begin
      pre[i]   = DW'($urandom);
      m_mem[i] = pre[i];
    end
    reset = 1'b1; req_valid = 1'b0; req_op = 1'b0;
    req_index = '0; req_tag = '0; req_state = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Release: sweep length and first ready cycle.
    n = 0; wes = 0;
    @(negedge clock);
    while (!req_ready && n < 30) begin
      if (ram_we) wes++;
      n++;
      @(negedge clock);
    end
    chk("release_we_cycles", wes, SWEEP_ON ? DEPTH : 0);
    chk("release_to_ready", n, SWEEP_ON ? DEPTH : 0);

`ifdef CACHE_TAG_INIT_SWEEP_EN
    do_req(1'b0, 3'd3, 9'h000, 2'b00, h, s, t, lat);
    chk("swept_lookup_hit", int'(h), 0);
    chk("swept_lookup_state", int'(s), 0);
`endif

    do_req(1'b1, 3'd5, 9'h0A3, 2'b10, h, s, t, lat);
    chk("upd5_latency", lat, 2);
    chk("upd5_hit", int'(h), 1);
    chk("upd5_state", int'(s), 2);
    chk("upd5_tag", int'(t), 9'h0A3);

    do_req(1'b0, 3'd5, 9'h0A3, 2'b00, h, s, t, lat);
    chk("look5_latency", lat, 2);
    chk("look5_hit", int'(h), 1);
    chk("look5_state", int'(s), 2);

    do_req(1'b0, 3'd5, 9'h0A4, 2'b00, h, s, t, lat);
    chk("miss5_hit", int'(h), 0);
    chk("miss5_tag", int'(t), 9'h0A3);
    chk("miss5_state", int'(s), 2);

    do_req(1'b1, 3'd2, 9'h1FF, 2'b11, h, s, t, lat);
    chk("upd2_rsvd_state", int'(s), 0);
    chk("ram2_state", int'(mem[2][DW-1:TW]), 0);
    do_req(1'b0, 3'd2, 9'h1FF, 2'b00, h, s, t, lat);
    chk("look2_hit", int'(h), 0);
    chk("look2_state", int'(s), 0);

    do_req(1'b1, 3'd0, 9'h1FF, 2'b01, h, s, t, lat);
    do_req(1'b0, 3'd0, 9'h1FF, 2'b00, h, s, t, lat);
    chk("look0_ones_hit", int'(h), 1);
    chk("look0_ones_state", int'(s), 1);

    // Continuous valid: accepts land every third cycle.
    @(posedge clock); #1;
    req_valid = 1'b1; req_op = 1'b0; req_index = 3'd7; req_tag = 9'h055;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (req_ready) acc_at.push_back(c);
    end
    @(posedge clock); #1 req_valid = 1'b0;
    acc = acc_at.size();
    chk("b2b_accepts", acc, 4);
    for (int k = 1; k < acc; k++) chk("b2b_spacing", acc_at[k] - acc_at[k-1], 3);

    // Reset during LOOK aborts the request.
    repeat (3) @(posedge clock);
    #1;
    req_valid = 1'b1; req_op = 1'b0; req_index = 3'd5; req_tag = 9'h0A3;
    n = 0;
    @(negedge clock);
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock); #1;
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clock);
    chk("abort_rsp_in_reset", int'(rsp_valid), 0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("abort_rsp_after", int'(rsp_valid), 0);
`ifdef CACHE_TAG_INIT_SWEEP_EN
    chk("abort_sweep_we", int'(ram_we), 1);
    chk("abort_sweep_addr", int'(ram_addr), 0);
`else
    chk("abort_ready_next", int'(req_ready), 1);
`endif
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("abort_no_rsp", int'(rsp_valid), 0);
    end

    // Random phase with a small tag pool so hits are common.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clock); #1;
      reset     = ($urandom_range(0, 59) == 0);
      req_valid = ($urandom_range(0, 2) != 0);
      req_op    = 1'($urandom_range(0, 1));
      req_index = AW'($urandom);
      req_state = 2'($urandom);
      case ($urandom_range(0, 3))
        0:       req_tag = 9'h000;
        1:       req_tag = 9'h1FF;
        2:       req_tag = 9'h0A3;
        default: req_tag = TW'($urandom);
      endcase
    end
    @(posedge clock); #1;
    reset = 1'b0; req_valid = 1'b0;
    repeat (DEPTH + 4) @(posedge clock);
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
